mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters: none; all widths SHALL be fixed at 32-bit address/data.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 mem_valid  in  1  M stage holds a load/store.
REQ-005 mem_op  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW.
REQ-006 mem_addr  in  32  effective address; mem_wdata  in  32  rt value for stores.
REQ-007 flush  in  1  exception/ERET flush of the M stage.
REQ-008 data_req / data_wr  out  1 / 1; data_size  out  2 (0 byte, 1 half, 2 word); data_wstrb  out  4; data_addr  out  32; data_wdata  out  32.
REQ-009 data_addr_ok / data_data_ok  in  1 / 1; data_rdata  in  32.
REQ-010 mem_stall  out  1  freezes F..M; load_valid  out  1; load_data  out  32; adel / ades  out  1 / 1.

Function
REQ-011 FSM states: IDLE, REQ, WAIT, DONE, CANCEL.
REQ-012 IDLE: mem_valid & ~flush & ~misaligned SHALL latch op/addr/wdata and go REQ; otherwise stay IDLE.
REQ-013 REQ: data_req=1 from latched fields; addr_ok -> WAIT; flush & ~addr_ok -> IDLE, nothing issued; flush & addr_ok -> CANCEL.
REQ-014 WAIT: data_ok -> DONE with rdata captured; flush & ~data_ok -> CANCEL; flush & data_ok -> IDLE, no load_valid.
REQ-015 CANCEL: absorbs one outstanding data_ok, then IDLE; no load_valid pulse.
REQ-016 DONE: load_valid=1 for exactly one cycle, mem_stall=0, then IDLE.
REQ-017 mem_stall = (state==CANCEL) | (mem_valid & state!=DONE & ~adel & ~ades & ~flush).
REQ-018 Minimum latency with zero-wait memory: launch t, REQ t+1 (addr_ok), data_ok t+2, DONE t+3; 3 stall cycles.
REQ-019 data_wstrb: SB one-hot at addr[1:0]; SH 0011/1100 by addr[1]; SW 1111; loads 0000.
REQ-020 data_wdata: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
REQ-021 load_data: byte/half at addr[1:0] from rdata; LB/LH sign-extended, LBU/LHU zero-extended, LW unchanged; stores leave load_data unchanged.
REQ-022 data_req SHALL only drop after addr_ok; latched fields SHALL NOT change while in REQ.
REQ-023 At most one outstanding transaction; data_ok outside WAIT/CANCEL SHALL be ignored.

Reset
REQ-024 rst SHALL force IDLE; data_req, data_wr, load_valid, mem_stall, adel, ades = 0; load_data, data_addr, data_wdata, data_wstrb, data_size = 0.
REQ-025 rst mid-transaction SHALL abandon it; data_ok after reset is ignored by REQ-023.

Configuration
REQ-026 Macro MEM_ALIGN_CHECK_EN defined: in IDLE with mem_valid, misaligned LH/LHU (addr[0]) or LW (addr[1:0]!=0) SHALL assert adel combinationally, misaligned SH/SW SHALL assert ades; no request issued, mem_stall=0.
REQ-027 Undefined: adel=ades=0; misaligned accesses issue with data_addr low bits forced to the size alignment.

Structure
REQ-028 Shared package mem_ctrl_pkg SHALL hold mem_op encodings, data_size codes and the FSM state encoding.
REQ-029 Combinational sub-module load_align SHALL implement REQ-021 extraction/extension.

Verification
REQ-030 LW 0x100, addr_ok/data_ok zero-wait, rdata 0xDEADBEEF -> stall 3 cycles, load_valid one cycle, load_data 0xDEADBEEF.
REQ-031 LB addr 0x103, rdata 0x80112233 -> load_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-032 SH addr 0x102, wdata 0x0000ABCD -> data_wstrb 1100, data_wdata 0xABCDABCD, data_size 1, data_wr 1.
REQ-033 flush in WAIT, data_ok 2 cycles later -> CANCEL, no load_valid, stall held until data_ok, then IDLE.
REQ-034 addr_ok held low 5 cycles -> data_req and data_addr stable all 5 cycles.
REQ-035 With MEM_ALIGN_CHECK_EN, LW addr 0x102 -> adel=1, data_req=0, mem_stall=0; without it -> data_addr 0x100 issued.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the M-stage data-memory access controller:
// load/store opcode encodings, bus transfer-size codes and FSM states.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LBU = 3'b001,
        OP_LH  = 3'b010,
        OP_LHU = 3'b011,
        OP_LW  = 3'b100,
        OP_SB  = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } mem_op_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } data_size_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DONE   = 3'd3,
        ST_CANCEL = 3'd4
    } state_e;

    function automatic data_size_e op_size(input mem_op_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SIZE_BYTE;
            OP_LH, OP_LHU, OP_SH: return SIZE_HALF;
            default:              return SIZE_WORD;
        endcase
    endfunction

    function automatic logic op_is_store(input mem_op_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the access controller (master) and memory (slave).
interface mem_access_ctrl_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_access_ctrl_load_align.sv
// Load data alignment: picks the addressed byte/half out of the read word
// and sign- or zero-extends it according to the load opcode.
module load_align
    import mem_ctrl_pkg::*;
(
    input  mem_op_e     op_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
    assign half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // Extend the selected lane to 32 bits; words pass through untouched.
    always_comb begin
        data_o = rdata_i;
        case (op_i)
            OP_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data_o = {24'h000000, byte_sel};
            OP_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data_o = {16'h0000, half_sel};
            default: data_o = rdata_i;
        endcase
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// M-stage load/store controller: issues one bus transaction per memory
// instruction, stalls the pipeline until it completes, and discards the
// response of a transaction killed by an exception/ERET flush.
// Optional feature macro MEM_ALIGN_CHECK_EN: when defined, misaligned
// half/word accesses raise adel/ades instead of issuing; when undefined the
// address low bits are forced to the access-size alignment.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic [2:0]        mem_op,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic              flush,
    mem_access_ctrl_if.master bus,
    output logic              mem_stall,
    output logic              load_valid,
    output logic [31:0]       load_data,
    output logic              adel,
    output logic              ades
);
    state_e      state_q, state_d;
    mem_op_e     op_q;
    data_size_e  size_q;
    logic [31:0] addr_q, wdata_q, load_data_q;
    logic [3:0]  wstrb_q;

    mem_op_e     op_in;
    data_size_e  size_in;
    logic [31:0] addr_in, wdata_in, aligned_rdata;
    logic [3:0]  wstrb_in;
    logic        mis_load, mis_store, launch, capture;

    assign op_in   = mem_op_e'(mem_op);
    assign size_in = op_size(op_in);

    // Misalignment detection for the instruction waiting in IDLE.
    always_comb begin
        mis_load  = 1'b0;
        mis_store = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        if (mem_valid && state_q == ST_IDLE) begin
            case (op_in)
                OP_LH, OP_LHU: mis_load  = mem_addr[0];
                OP_LW:         mis_load  = |mem_addr[1:0];
                OP_SH:         mis_store = mem_addr[0];
                OP_SW:         mis_store = |mem_addr[1:0];
                default: ;
            endcase
        end
`endif
    end

    // Bus fields for a new request: size-aligned address, byte strobes and
    // store data replicated across every lane it may land in.
    always_comb begin
        addr_in  = mem_addr;
        wstrb_in = 4'b0000;
        wdata_in = mem_wdata;
        case (size_in)
            SIZE_HALF: addr_in = {mem_addr[31:1], 1'b0};
            SIZE_WORD: addr_in = {mem_addr[31:2], 2'b00};
            default: ;
        endcase
        case (op_in)
            OP_SB: begin
                wstrb_in = 4'b0001 << addr_in[1:0];
                wdata_in = {4{mem_wdata[7:0]}};
            end
            OP_SH: begin
                wstrb_in = addr_in[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{mem_wdata[15:0]}};
            end
            OP_SW:   wstrb_in = 4'b1111;
            default: ;
        endcase
    end

    // Next-state logic; a flush either drops an unaccepted request or
    // diverts an accepted one to CANCEL so its data_ok is swallowed.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_valid && !flush && !mis_load && !mis_store) begin
                    launch  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.data_addr_ok) state_d = flush ? ST_CANCEL : ST_WAIT;
                else if (flush)       state_d = ST_IDLE;
            end
            ST_WAIT: begin
                if (bus.data_data_ok) begin
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                        capture = !op_is_store(op_q);
                    end
                end else if (flush) begin
                    state_d = ST_CANCEL;
                end
            end
            ST_DONE:   state_d = ST_IDLE;
            ST_CANCEL: if (bus.data_data_ok) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State, request fields (frozen from launch until the next launch) and
    // the aligned load result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_LB;
            size_q      <= SIZE_BYTE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            load_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                op_q    <= op_in;
                size_q  <= size_in;
                addr_q  <= addr_in;
                wdata_q <= wdata_in;
                wstrb_q <= wstrb_in;
            end
            if (capture) load_data_q <= aligned_rdata;
        end
    end

    load_align u_load_align (
        .op_i     (op_q),
        .offset_i (addr_q[1:0]),
        .rdata_i  (bus.data_rdata),
        .data_o   (aligned_rdata)
    );

    assign bus.data_req   = (state_q == ST_REQ);
    assign bus.data_wr    = (state_q == ST_REQ) && op_is_store(op_q);
    assign bus.data_size  = size_q;
    assign bus.data_addr  = addr_q;
    assign bus.data_wdata = wdata_q;
    assign bus.data_wstrb = wstrb_q;

    assign load_valid = (state_q == ST_DONE);
    assign load_data  = load_data_q;
    assign adel       = mis_load && !rst;
    assign ades       = mis_store && !rst;
    assign mem_stall  = !rst && ((state_q == ST_CANCEL) ||
                        (mem_valid && state_q != ST_DONE && !mis_load && !mis_store && !flush));
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: fixed vector table, hand-built flush/reset
// sequences and random transactions against a behavioural model.
module tb_mem_access_ctrl;
    localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3,
                           LW = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, flush;
    logic [2:0]  mem_op;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_stall, load_valid, adel, ades;
    logic [31:0] load_data;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] model_ld;

    mem_access_ctrl_if bus();

    mem_access_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .mem_valid  (mem_valid),
        .mem_op     (mem_op),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .flush      (flush),
        .bus        (bus),
        .mem_stall  (mem_stall),
        .load_valid (load_valid),
        .load_data  (load_data),
        .adel       (adel),
        .ades       (ades)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr, wdata, ld;
        logic [3:0]  wstrb;
        logic [1:0]  size;
        logic        wr, stable, lv_after, timeout;
        int          stalls, lv, req_cycles;
    } obs_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr, wd, rd, e_addr;
        logic [3:0]  e_wstrb;
        logic [31:0] e_wdata;
        logic [1:0]  e_size;
        logic        e_wr;
        logic [31:0] e_ld;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        flush            = 1'b0;
    endtask

    // Hold one memory instruction in M until load_valid, answering addr_ok
    // after aw extra request cycles and data_ok after dw extra wait cycles.
    task automatic run_xact(input logic [2:0] op, input logic [31:0] addr, wd, rd,
                            input int aw, dw, output obs_t ob);
        bit accepted, acc_now, done;
        int req_cnt, wait_cnt;
        ob.addr = '0; ob.wdata = '0; ob.ld = '0; ob.wstrb = '0; ob.size = '0;
        ob.wr = 1'b0; ob.stable = 1'b1; ob.lv_after = 1'b0; ob.timeout = 1'b0;
        ob.stalls = 0; ob.lv = 0; ob.req_cycles = 0;
        accepted = 0; done = 0; req_cnt = 0; wait_cnt = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            tick();
            acc_now   = 0;
            mem_valid = 1'b1; mem_op = op; mem_addr = addr; mem_wdata = wd;
            bus.data_rdata = rd;
            #1;
            if (bus.data_req) begin
                if (ob.req_cycles == 0) begin
                    ob.addr = bus.data_addr; ob.wdata = bus.data_wdata;
                    ob.wstrb = bus.data_wstrb; ob.size = bus.data_size; ob.wr = bus.data_wr;
                end else if (bus.data_addr !== ob.addr || bus.data_wdata !== ob.wdata ||
                             bus.data_wstrb !== ob.wstrb || bus.data_size !== ob.size) begin
                    ob.stable = 1'b0;
                end
                ob.req_cycles++;
                if (req_cnt == aw) begin
                    bus.data_addr_ok = 1'b1;
                    acc_now = 1;
                end
                req_cnt++;
            end else if (accepted) begin
                if (wait_cnt == dw) bus.data_data_ok = 1'b1;
                wait_cnt++;
            end
            #1;
            if (mem_stall) ob.stalls++;
            if (load_valid) begin
                ob.lv++;
                ob.ld = load_data;
                done = 1;
            end
            if (acc_now) accepted = 1;
        end
        ob.timeout = !done;
        tick();
        mem_valid = 1'b0;
        #1;
        ob.lv_after = load_valid;
    endtask

    task automatic check_obs(input string tag, input obs_t ob, input logic [31:0] e_addr,
                             input logic [3:0] e_wstrb, input logic [31:0] e_wdata,
                             input logic [1:0] e_size, input logic e_wr, input logic [31:0] e_ld,
                             input int aw, dw);
        chk({tag, ".timeout"}, 32'(ob.timeout), 32'd0);
        chk({tag, ".addr"},    ob.addr, e_addr);
        chk({tag, ".wstrb"},   32'(ob.wstrb), 32'(e_wstrb));
        chk({tag, ".size"},    32'(ob.size), 32'(e_size));
        chk({tag, ".wr"},      32'(ob.wr), 32'(e_wr));
        if (e_wr) chk({tag, ".wdata"}, ob.wdata, e_wdata);
        chk({tag, ".stable"},  32'(ob.stable), 32'd1);
        chk({tag, ".reqcyc"},  32'(ob.req_cycles), 32'(aw + 1));
        chk({tag, ".stalls"},  32'(ob.stalls), 32'(3 + aw + dw));
        chk({tag, ".lv"},      32'(ob.lv), 32'd1);
        chk({tag, ".lv_after"}, 32'(ob.lv_after), 32'd0);
        chk({tag, ".ld"},      ob.ld, e_ld);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        obs_t ob;

        vecs[0]  = '{LW,  32'h100, 32'h0,        32'hDEADBEEF, 32'h100, 4'b0000, 32'h0,        2'd2, 1'b0, 32'hDEADBEEF};
        vecs[1]  = '{LB,  32'h103, 32'h0,        32'h80112233, 32'h103, 4'b0000, 32'h0,        2'd0, 1'b0, 32'hFFFFFF80};
        vecs[2]  = '{LBU, 32'h103, 32'h0,        32'h80112233, 32'h103, 4'b0000, 32'h0,        2'd0, 1'b0, 32'h00000080};
        vecs[3]  = '{SH,  32'h102, 32'h0000ABCD, 32'h0,        32'h102, 4'b1100, 32'hABCDABCD, 2'd1, 1'b1, 32'h00000080};
        vecs[4]  = '{LH,  32'h202, 32'h0,        32'h80017FFF, 32'h202, 4'b0000, 32'h0,        2'd1, 1'b0, 32'hFFFF8001};
        vecs[5]  = '{LHU, 32'h200, 32'h0,        32'h1234F00D, 32'h200, 4'b0000, 32'h0,        2'd1, 1'b0, 32'h0000F00D};
        vecs[6]  = '{SB,  32'h301, 32'h000000A5, 32'h0,        32'h301, 4'b0010, 32'hA5A5A5A5, 2'd0, 1'b1, 32'h0000F00D};
        vecs[7]  = '{SW,  32'h400, 32'h12345678, 32'h0,        32'h400, 4'b1111, 32'h12345678, 2'd2, 1'b1, 32'h0000F00D};
        vecs[8]  = '{LB,  32'h500, 32'h0,        32'h0000007F, 32'h500, 4'b0000, 32'h0,        2'd0, 1'b0, 32'h0000007F};
        vecs[9]  = '{LH,  32'h502, 32'h0,        32'h7FFF0000, 32'h502, 4'b0000, 32'h0,        2'd1, 1'b0, 32'h00007FFF};
        vecs[10] = '{SB,  32'h503, 32'h000000FF, 32'h0,        32'h503, 4'b1000, 32'hFFFFFFFF, 2'd0, 1'b1, 32'h00007FFF};
        vecs[11] = '{SH,  32'h600, 32'hFFFF1234, 32'h0,        32'h600, 4'b0011, 32'h12341234, 2'd1, 1'b1, 32'h00007FFF};

        // Reset with a valid aligned load present: everything must read zero.
        rst = 1'b1; mem_valid = 1'b1; mem_op = LW; mem_addr = 32'h40; mem_wdata = 32'h0; flush = 1'b0;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst.req",   32'(bus.data_req), 32'd0);
        chk("rst.wr",    32'(bus.data_wr), 32'd0);
        chk("rst.lv",    32'(load_valid), 32'd0);
        chk("rst.stall", 32'(mem_stall), 32'd0);
        chk("rst.adel",  32'(adel), 32'd0);
        chk("rst.ades",  32'(ades), 32'd0);
        chk("rst.ld",    load_data, 32'd0);
        chk("rst.addr",  bus.data_addr, 32'd0);
        chk("rst.wdata", bus.data_wdata, 32'd0);
        chk("rst.wstrb", 32'(bus.data_wstrb), 32'd0);
        chk("rst.size",  32'(bus.data_size), 32'd0);
        mem_valid = 1'b0;
        rst = 1'b0;

        // Fixed vectors, zero-wait memory.
        for (int i = 0; i < 12; i++) begin
            run_xact(vecs[i].op, vecs[i].addr, vecs[i].wd, vecs[i].rd, 0, 0, ob);
            check_obs($sformatf("vec%0d", i), ob, vecs[i].e_addr, vecs[i].e_wstrb, vecs[i].e_wdata,
                      vecs[i].e_size, vecs[i].e_wr, vecs[i].e_ld, 0, 0);
        end
        model_ld = 32'h00007FFF;

        // addr_ok held off for 5 cycles: request must stay put.
        run_xact(LW, 32'hA00, 32'h0, 32'h0BADF00D, 5, 1, ob);
        check_obs("slow_addr", ob, 32'hA00, 4'b0000, 32'h0, 2'd2, 1'b0, 32'h0BADF00D, 5, 1);
        model_ld = 32'h0BADF00D;

        // Misaligned word load.
`ifdef MEM_ALIGN_CHECK_EN
        tick(); mem_valid = 1'b1; mem_op = LW; mem_addr = 32'h102; #1;
        chk("mis_lw.adel",  32'(adel), 32'd1);
        chk("mis_lw.ades",  32'(ades), 32'd0);
        chk("mis_lw.req",   32'(bus.data_req), 32'd0);
        chk("mis_lw.stall", 32'(mem_stall), 32'd0);
        tick(); #1;
        chk("mis_lw.req2",  32'(bus.data_req), 32'd0);
        mem_op = SW; mem_addr = 32'h101; #1;
        chk("mis_sw.ades",  32'(ades), 32'd1);
        chk("mis_sw.adel",  32'(adel), 32'd0);
        tick(); mem_valid = 1'b0; #1;
        chk("mis_sw.req",   32'(bus.data_req), 32'd0);
`else
        run_xact(LW, 32'h102, 32'h0, 32'hCAFEF00D, 0, 0, ob);
        check_obs("mis_lw", ob, 32'h100, 4'b0000, 32'h0, 2'd2, 1'b0, 32'hCAFEF00D, 0, 0);
        model_ld = 32'hCAFEF00D;
        tick(); mem_valid = 1'b1; mem_op = SW; mem_addr = 32'h101; #1;
        chk("mis_sw.ades", 32'(ades), 32'd0);
        mem_valid = 1'b0;
`endif

        // Flush while waiting for data; data_ok arrives two cycles later.
        tick(); mem_valid = 1'b1; mem_op = LW; mem_addr = 32'h900; bus.data_rdata = 32'h55555555; #1;
        tick(); bus.data_addr_ok = 1'b1; #1;
        tick(); flush = 1'b1; #1;
        chk("flw.lv0", 32'(load_valid), 32'd0);
        tick(); mem_valid = 1'b0; #1;
        chk("flw.stall1", 32'(mem_stall), 32'd1);
        chk("flw.lv1",    32'(load_valid), 32'd0);
        tick(); bus.data_data_ok = 1'b1; #1;
        chk("flw.stall2", 32'(mem_stall), 32'd1);
        chk("flw.lv2",    32'(load_valid), 32'd0);
        tick(); #1;
        chk("flw.stall3", 32'(mem_stall), 32'd0);
        chk("flw.lv3",    32'(load_valid), 32'd0);
        chk("flw.req3",   32'(bus.data_req), 32'd0);
        chk("flw.ld",     load_data, model_ld);
        // Stray data_ok in IDLE is ignored.
        tick(); bus.data_data_ok = 1'b1; #1;
        tick(); #1;
        chk("stray.lv",  32'(load_valid), 32'd0);
        chk("stray.req", 32'(bus.data_req), 32'd0);

        // Flush in REQ without addr_ok: request dropped.
        tick(); mem_valid = 1'b1; mem_op = SW; mem_addr = 32'h800; mem_wdata = 32'h1; #1;
        tick(); #1;
        chk("flreq.req_on", 32'(bus.data_req), 32'd1);
        flush = 1'b1; #1;
        tick(); mem_valid = 1'b0; #1;
        chk("flreq.req_off", 32'(bus.data_req), 32'd0);
        chk("flreq.stall",   32'(mem_stall), 32'd0);

        // Flush in REQ coinciding with addr_ok: response must be absorbed.
        tick(); mem_valid = 1'b1; mem_op = LW; mem_addr = 32'h840; bus.data_rdata = 32'h77777777; #1;
        tick(); bus.data_addr_ok = 1'b1; flush = 1'b1; #1;
        tick(); mem_valid = 1'b0; #1;
        chk("flacc.stall", 32'(mem_stall), 32'd1);
        chk("flacc.req",   32'(bus.data_req), 32'd0);
        bus.data_data_ok = 1'b1; #1;
        tick(); #1;
        chk("flacc.stall2", 32'(mem_stall), 32'd0);
        chk("flacc.lv",     32'(load_valid), 32'd0);
        chk("flacc.ld",     load_data, model_ld);

        // Random transactions against the reference model.
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  op;
            logic [31:0] a, wd, rd, ea, ewd, v, eld;
            logic [3:0]  ews;
            logic [1:0]  esz;
            int          sz, off, aw, dw;
            bit          st;
            op = 3'($urandom_range(0, 7));
            a  = $urandom; wd = $urandom; rd = $urandom;
            aw = $urandom_range(0, 3); dw = $urandom_range(0, 3);
            sz = (op == LW || op == SW) ? 4 : (op == LH || op == LHU || op == SH) ? 2 : 1;
`ifdef MEM_ALIGN_CHECK_EN
            a = a & ~(32'(sz - 1));
`endif
            ea  = a - (a % 32'(sz));
            off = int'(ea % 32'd4);
            st  = (op >= SB);
            esz = (sz == 1) ? 2'd0 : (sz == 2) ? 2'd1 : 2'd2;
            ews = st ? 4'(((1 << sz) - 1) << off) : 4'b0000;
            ewd = (sz == 1) ? {24'h0, wd[7:0]} * 32'h01010101 :
                  (sz == 2) ? {16'h0, wd[15:0]} * 32'h00010001 : wd;
            v   = rd >> (8 * off);
            eld = model_ld;
            case (op)
                LB:  eld = (v & 32'hFF)   | (v[7]  ? 32'hFFFFFF00 : 32'h0);
                LBU: eld =  v & 32'hFF;
                LH:  eld = (v & 32'hFFFF) | (v[15] ? 32'hFFFF0000 : 32'h0);
                LHU: eld =  v & 32'hFFFF;
                LW:  eld =  rd;
                default: ;
            endcase
            model_ld = eld;
            run_xact(op, a, wd, rd, aw, dw, ob);
            check_obs($sformatf("rnd%0d", n), ob, ea, ews, ewd, esz, st, eld, aw, dw);
        end

        // Reset in the middle of a transaction; the late data_ok is ignored.
        tick(); mem_valid = 1'b1; mem_op = LW; mem_addr = 32'h700; bus.data_rdata = 32'h11111111; #1;
        tick(); bus.data_addr_ok = 1'b1; #1;
        tick(); rst = 1'b1; mem_valid = 1'b0; #1;
        tick(); rst = 1'b0; bus.data_data_ok = 1'b1; #1;
        chk("rstmid.stall", 32'(mem_stall), 32'd0);
        chk("rstmid.req",   32'(bus.data_req), 32'd0);
        tick(); #1;
        chk("rstmid.lv", 32'(load_valid), 32'd0);
        chk("rstmid.ld", load_data, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
